// File: rtl/fp_pool_pkg.sv
// -----------------------------------------------------------------------------
// fp_pool_pkg
// Shared helpers for the small sign/exponent/mantissa float format used in the
// CNN datapath (fp_relu, fp_maxpool2x2, fp_max users).
//   fp_width   : word width for a given EXP/MANT split (1 sign bit + EXP + MANT)
//   fp_bias    : exponent bias for a given EXP width
//   fp_max_val : sign-magnitude max of two words; ties (including +0 vs -0)
//                return the first operand
// The format has no denormals, NaN or infinity, so the ordering is a plain
// sign-magnitude compare on the packed word.
// -----------------------------------------------------------------------------
package fp_pool_pkg;

   // Widest word fp_max_val can handle; narrower words are zero-extended.
   localparam int FP_MAX_W = 32;

   localparam int DEFAULT_EXP  = 4;
   localparam int DEFAULT_MANT = 4;

   function automatic int fp_width(input int exp_w, input int mant_w);
      return 1 + exp_w + mant_w;
   endfunction

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Bias of the default format: 1.0 encodes as exponent field == BIAS.
   localparam int BIAS = fp_bias(DEFAULT_EXP);

   // a and b hold a w-bit word in their low bits; the sign is bit w-1.
   function automatic logic [FP_MAX_W-1:0] fp_max_val(
      input logic [FP_MAX_W-1:0] a,
      input logic [FP_MAX_W-1:0] b,
      input int                  w
   );
      logic [FP_MAX_W-1:0] mask;
      logic [FP_MAX_W-1:0] mag_a;
      logic [FP_MAX_W-1:0] mag_b;
      logic                sgn_a;
      logic                sgn_b;
      logic                b_wins;
      mask   = {FP_MAX_W{1'b1}} >> (FP_MAX_W - w + 1);
      mag_a  = a & mask;
      mag_b  = b & mask;
      sgn_a  = a[w-1];
      sgn_b  = b[w-1];
      b_wins = 1'b0;
      if ((mag_a == '0) && (mag_b == '0)) begin
         // +0 and -0 compare equal: keep the first operand.
         b_wins = 1'b0;
      end else if (sgn_a != sgn_b) begin
         // Mixed signs: the positive operand wins.
         b_wins = sgn_a;
      end else if (!sgn_a) begin
         b_wins = (mag_b > mag_a);
      end else begin
         // Both negative: smaller magnitude is the larger value.
         b_wins = (mag_b < mag_a);
      end
      return b_wins ? b : a;
   endfunction

endpackage

// File: rtl/fp_max_comb.sv
// -----------------------------------------------------------------------------
// fp_max_comb
// Combinational max of two floats in the sign/EXP/MANT format.
// Ports:
//   a  in  WIDTH  first operand (returned on ties)
//   b  in  WIDTH  second operand
//   y  out WIDTH  max(a, b)
// -----------------------------------------------------------------------------
module fp_max_comb
   import fp_pool_pkg::*;
#(
   parameter int EXP  = 4,
   parameter int MANT = 4
) (
   input  logic [fp_width(EXP, MANT)-1:0] a,
   input  logic [fp_width(EXP, MANT)-1:0] b,
   output logic [fp_width(EXP, MANT)-1:0] y
);

   localparam int W = fp_width(EXP, MANT);

   logic [FP_MAX_W-1:0] a_ext;
   logic [FP_MAX_W-1:0] b_ext;

   assign a_ext = FP_MAX_W'(a);
   assign b_ext = FP_MAX_W'(b);
   assign y     = W'(fp_max_val(a_ext, b_ext, W));

endmodule

// File: rtl/fp_maxpool2x2.sv
// -----------------------------------------------------------------------------
// fp_maxpool2x2
// Streaming 2x2 / stride-2 max-pool over one feature-map channel delivered in
// row-major order, one pixel per data_valid, no backpressure.
// Ports:
//   clock         in   1      rising-edge clock
//   clock_sreset  in   1      synchronous reset, active-low
//   data_valid    in   1      dataa holds the next pixel this cycle
//   dataa         in   WIDTH  input pixel
//   result_valid  out  1      result holds a pooled value this cycle
//   result        out  WIDTH  max of the 2x2 window (holds when not valid)
//   frame_done    out  1      pulse with the last result of a frame
// Even-column pixels are parked in hold_q; on the odd column the horizontal
// pair max is either stored in the line buffer (even row) or combined with
// the stored value of the row above to form the window result (odd row).
// -----------------------------------------------------------------------------
module fp_maxpool2x2
   import fp_pool_pkg::*;
#(
   parameter int EXP   = 4,
   parameter int MANT  = 4,
   parameter int WIDTH = fp_width(EXP, MANT),
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic             clock,
   input  logic             clock_sreset,
   input  logic             data_valid,
   input  logic [WIDTH-1:0] dataa,
   output logic             result_valid,
   output logic [WIDTH-1:0] result,
   output logic             frame_done
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int LB_N  = IMG_W / 2;
   localparam int LB_W  = (LB_N > 1) ? $clog2(LB_N) : 1;

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             frame_done_q, frame_done_d;

   // Line buffer: one pair max per column pair of the previous even row.
   // Not reset; every entry is written on an even row before it is read.
   logic [WIDTH-1:0] lbuf_q [LB_N];
   logic             lbuf_we;
   logic [WIDTH-1:0] lbuf_wdata;
   logic [LB_W-1:0]  lb_idx;

   logic [WIDTH-1:0] pair_max;
   logic [WIDTH-1:0] win_max;
   logic             col_last;
   logic             row_last;

   assign lb_idx   = LB_W'(col_q >> 1);
   assign col_last = (col_q == COL_W'(IMG_W - 1));
   assign row_last = (row_q == ROW_W'(IMG_H - 1));

   // Held (earlier) pixel is operand a so it wins ties.
   fp_max_comb #(.EXP(EXP), .MANT(MANT)) u_pair_max (
      .a (hold_q),
      .b (dataa),
      .y (pair_max)
   );

   // Line-buffer value is operand a so the upper row wins ties.
   fp_max_comb #(.EXP(EXP), .MANT(MANT)) u_win_max (
      .a (lbuf_q[lb_idx]),
      .b (pair_max),
      .y (win_max)
   );

   always_comb begin
      col_d          = col_q;
      row_d          = row_q;
      hold_d         = hold_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      frame_done_d   = 1'b0;
      lbuf_we        = 1'b0;
      lbuf_wdata     = pair_max;
      if (data_valid) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
         if (!col_q[0]) begin
            hold_d = dataa;
         end else if (!row_q[0]) begin
            lbuf_we = 1'b1;
         end else begin
            result_d       = win_max;
            result_valid_d = 1'b1;
            frame_done_d   = row_last && col_last;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!clock_sreset) begin
         col_q          <= '0;
         row_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         col_q          <= col_d;
         row_q          <= row_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         frame_done_q   <= frame_done_d;
      end
   end

   // Datapath storage without reset: contents are don't-care after reset.
   always_ff @(posedge clock) begin
      hold_q <= hold_d;
      if (lbuf_we) begin
         lbuf_q[lb_idx] <= lbuf_wdata;
      end
   end

   assign result_valid = result_valid_q;
   assign result       = result_q;
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_fp_maxpool2x2.sv
// -----------------------------------------------------------------------------
// tb_fp_maxpool2x2
// Directed bench for fp_maxpool2x2 with a 4x4 image of 9-bit floats.
// A table of 2x2 windows (pixels TL, TR, BL, BR plus hand-computed max) is
// laid out into row-major frames; four consecutive windows make one frame.
// -----------------------------------------------------------------------------
module tb_fp_maxpool2x2;

   localparam int EXP   = 4;
   localparam int MANT  = 4;
   localparam int W     = 9;
   localparam int IMG_W = 4;
   localparam int IMG_H = 4;

   // ---------------- clock / reset ----------------
   logic         clock = 1'b0;
   logic         clock_sreset;
   logic         data_valid;
   logic [W-1:0] dataa;
   logic         result_valid;
   logic [W-1:0] result;
   logic         frame_done;

   always #5 clock = ~clock;

   fp_maxpool2x2 #(
      .EXP   (EXP),
      .MANT  (MANT),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) dut (
      .clock        (clock),
      .clock_sreset (clock_sreset),
      .data_valid   (data_valid),
      .dataa        (dataa),
      .result_valid (result_valid),
      .result       (result),
      .frame_done   (frame_done)
   );

   // ---------------- vectors ----------------
   typedef struct {
      logic [W-1:0] px [4];
      logic [W-1:0] exp;
   } win_t;

   win_t tbl [8];

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q [$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           fd_cnt   = 0;
   logic         tb_close = 1'b0;
   logic         tb_last  = 1'b0;
   logic         due_q    = 1'b0;
   logic         due_fd_q = 1'b0;
   logic         mon_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // A result is due exactly one cycle after an accepted window-closing pixel.
   always @(posedge clock) begin
      due_q    <= clock_sreset & data_valid & tb_close;
      due_fd_q <= clock_sreset & data_valid & tb_close & tb_last;
   end

   always @(negedge clock) begin
      logic [W-1:0] e;
      if (mon_en) begin
         check("result_valid", 32'(result_valid), 32'(due_q));
         check("frame_done", 32'(frame_done), 32'(due_fd_q));
         if (result_valid) begin
            if (frame_done) fd_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL result_unexpected: got %h, expected no result", result);
            end else begin
               e = exp_q.pop_front();
               check("result", 32'(result), 32'(e));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_pixel(input logic [W-1:0] px, input logic close,
                              input logic last, input logic [W-1:0] e);
      @(negedge clock);
      data_valid = 1'b1;
      dataa      = px;
      tb_close   = close;
      tb_last    = last;
      if (close) exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         data_valid = 1'b0;
         dataa      = W'($urandom);
         tb_close   = 1'b0;
         tb_last    = 1'b0;
      end
   endtask

   // Sends the first n_px pixels of the frame built from tbl[base..base+3].
   task automatic send_frame(input int base, input int max_gap, input int n_px);
      int w;
      int k;
      int sent;
      sent = 0;
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            if (sent < n_px) begin
               w = (r / 2) * (IMG_W / 2) + (c / 2);
               k = (r % 2) * 2 + (c % 2);
               drive_pixel(tbl[base+w].px[k], (k == 3),
                           (r == IMG_H - 1) && (c == IMG_W - 1), tbl[base+w].exp);
               sent++;
               if (max_gap > 0) idle($urandom_range(0, max_gap));
            end
         end
      end
   endtask

   task automatic do_reset(input int n, input logic dv);
      @(negedge clock);
      clock_sreset = 1'b0;
      data_valid   = dv;
      dataa        = W'($urandom);
      tb_close     = 1'b0;
      tb_last      = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
         check("reset_result_valid", 32'(result_valid), 32'd0);
         check("reset_result", 32'(result), 32'd0);
         check("reset_frame_done", 32'(frame_done), 32'd0);
      end
      @(negedge clock);
      clock_sreset = 1'b1;
      data_valid   = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      // Frame A: basic windows, zeros, negatives.
      tbl[0].px = '{9'h070, 9'h080, 9'h060, 9'h060}; tbl[0].exp = 9'h080;
      tbl[1].px = '{9'h060, 9'h060, 9'h090, 9'h070}; tbl[1].exp = 9'h090;
      tbl[2].px = '{9'h000, 9'h100, 9'h100, 9'h100}; tbl[2].exp = 9'h000;
      tbl[3].px = '{9'h170, 9'h180, 9'h160, 9'h190}; tbl[3].exp = 9'h160;
      // Frame B: different data so stale line-buffer contents would show.
      tbl[4].px = '{9'h090, 9'h010, 9'h020, 9'h030}; tbl[4].exp = 9'h090;
      tbl[5].px = '{9'h1F0, 9'h100, 9'h1F0, 9'h1F0}; tbl[5].exp = 9'h100;
      tbl[6].px = '{9'h005, 9'h004, 9'h006, 9'h003}; tbl[6].exp = 9'h006;
      tbl[7].px = '{9'h1A0, 9'h001, 9'h180, 9'h1FF}; tbl[7].exp = 9'h001;

      clock_sreset = 1'b0;
      data_valid   = 1'b1;
      dataa        = '0;

      // Reset held 3 cycles with data_valid high.
      do_reset(3, 1'b1);
      mon_en = 1'b1;

      // Frame A, no gaps; then check that result holds while idle.
      send_frame(0, 0, 16);
      idle(3);
      check("hold_result", 32'(result), 32'h160);
      check("hold_valid", 32'(result_valid), 32'd0);

      // Frame A with random idle gaps, including inside pairs.
      send_frame(0, 3, 16);
      idle(2);

      // Partial frame B dropped by a mid-frame reset, then a full frame A.
      send_frame(4, 0, 5);
      do_reset(1, 1'b0);
      send_frame(0, 0, 16);

      // Back-to-back frames A then B with no gap.
      send_frame(0, 0, 16);
      send_frame(4, 0, 16);
      idle(4);

      check("frame_done_count", 32'(fd_cnt), 32'd5);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
